vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DIV      4    CLK cycles per pixel (100 MHz CLK to 25 MHz pixel rate)
  H_VIS    640  visible pixels per line
  H_FP     16   horizontal front porch
  H_SYNC   96   horizontal sync width
  H_BP     48   horizontal back porch (line total 800)
  V_VIS    480  visible lines
  V_FP     10   vertical front porch
  V_SYNC   2    vertical sync width
  V_BP     33   vertical back porch (frame total 525)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CLK         in   1   system clock, rising edge
  RESETN      in   1   asynchronous active-low reset
  COLOUR_IN   in   12  RGB444 colour for the pixel addressed by ADDRH/ADDRV
  ADDRH       out  10  current pixel column, 0..639
  ADDRV       out  9   current pixel row, 0..479
  COLOUR_OUT  out  12  RGB444 to DAC, 0 during blanking
  HS          out  1   horizontal sync, active low
  VS          out  1   vertical sync, active low
  FRAME       out  1   start-of-vertical-blank strobe
REQ-003 The block SHALL use one clock, CLK; reset SHALL be asynchronous and active-low on RESETN.

Function
REQ-004 A 2-bit divider SHALL count 0..DIV-1 on every CLK edge; tick SHALL be true in the cycle where divider = DIV-1.
REQ-005 hcnt (10 bit) SHALL advance only on tick edges, wrapping 799 -> 0.
REQ-006 vcnt (10 bit) SHALL advance on the tick edge where hcnt wraps, wrapping 524 -> 0; both wraps on the same edge SHALL take hcnt and vcnt to 0,0.
REQ-007 ADDRH and ADDRV SHALL be registers loaded on the tick edge from the new counter values. ADDRH SHALL be hcnt when hcnt < 640, else 0. ADDRV SHALL be vcnt[8:0] when vcnt < 480, else 0.
REQ-008 Stage 2: pix_h and pix_v SHALL register the pre-increment hcnt and vcnt on each tick edge. This marks the pixel whose colour the wrapper presented during the elapsed pixel period.
REQ-009 On each tick edge, COLOUR_OUT SHALL load COLOUR_IN if (hcnt < 640 and vcnt < 480) before the increment. Otherwise COLOUR_OUT SHALL load 0.
REQ-010 HS SHALL be registered low exactly while 656 <= pix_h <= 751, and high otherwise.
REQ-011 VS SHALL be registered low exactly while 490 <= pix_v <= 491, and high otherwise.
REQ-012 HS, VS and COLOUR_OUT SHALL change only on tick edges and SHALL stay mutually aligned to the same pixel.
REQ-013 FRAME SHALL be a register set on the tick edge whose new counter values are hcnt = 0, vcnt = 480. It SHALL be high for exactly DIV CLK cycles, once per frame.
REQ-014 COLOUR_IN SHALL be sampled only on tick edges; it may change freely between ticks.
REQ-015 Latency SHALL be: address presented at tick k, then colour/sync for that pixel driven at tick k+1 (DIV CLKs).
REQ-016 All outputs SHALL be driven directly from flops, with no combinational paths from COLOUR_IN.

Reset
REQ-017 While RESETN = 0, the following SHALL hold immediately regardless of CLK: divider = 0, hcnt = vcnt = 0, pix_h = pix_v = 0, ADDRH = ADDRV = 0, COLOUR_OUT = 0, HS = VS = 1, FRAME = 0.
REQ-018 Reset asserted mid-line or mid-frame SHALL abort the frame. After release, the first tick SHALL occur on the 4th CLK rising edge, with hcnt 0 -> 1.
REQ-019 Tick n after release SHALL fall on CLK edge 4n.

Verification
REQ-020 Release reset, COLOUR_IN = 12'hABC -> edge 4: ADDRH = 1, COLOUR_OUT = 12'hABC. Edge 2564 (pix_h 640): COLOUR_OUT = 0. Edge 3204: COLOUR_OUT = 12'hABC, ADDRV = 1.
REQ-021 Free run, line 0 -> HS falls at edge 2628, rises at edge 3012; period 3200 CLKs; 96 pixels low.
REQ-022 Free run -> FRAME rises at edge 1,536,000 and is high 4 CLKs. VS is low from edge 4*(490*800+1) for 1600 pixels. Next FRAME comes 1,680,000 CLKs later.
REQ-023 Drive COLOUR_IN = {ADDRV[3:0], ADDRH[7:0]} each cycle -> COLOUR_OUT at tick k+1 equals the address value at tick k for every visible pixel of a frame; it is 0 for all 160 blank pixels per line and all 45 blank lines.
REQ-024 Assert RESETN low for 3 CLKs mid-edge at hcnt = 700, vcnt = 300 -> all outputs at reset values asynchronously. After release, ADDRH = 1 at the 4th edge and no FRAME pulse before edge 1,536,000.
REQ-025 Counter wrap at hcnt = 799, vcnt = 524 -> next tick gives ADDRH = 0, ADDRV = 0, and the following tick drives the colour for pixel (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator. A CLK divider produces one pixel tick every
//   DIV cycles. Horizontal and vertical counters walk the full raster, which
//   includes the blanking intervals. The block presents the pixel address one
//   tick ahead of the colour/sync it drives, so an external frame buffer has
//   one pixel period to return COLOUR_IN.
//
// Ports
//   CLK        in   system clock, rising edge
//   RESETN     in   asynchronous active-low reset
//   COLOUR_IN  in   RGB444 colour for the pixel at ADDRH/ADDRV (sampled on tick)
//   ADDRH      out  visible column 0..H_VIS-1, 0 during horizontal blanking
//   ADDRV      out  visible row 0..V_VIS-1, 0 during vertical blanking
//   COLOUR_OUT out  RGB444 to DAC, 0 during blanking
//   HS         out  horizontal sync, active low
//   VS         out  vertical sync, active low
//   FRAME      out  one-pixel strobe at the start of vertical blanking
module vga_timing_gen #(
  parameter int DIV    = 4,    // 1..4, the divider is 2 bits wide
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [11:0] COLOUR_IN,
  output logic [9:0]  ADDRH,
  output logic [8:0]  ADDRV,
  output logic [11:0] COLOUR_OUT,
  output logic        HS,
  output logic        VS,
  output logic        FRAME
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_VIS + H_FP;
  localparam int HS_LAST  = H_VIS + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_VIS + V_FP;
  localparam int VS_LAST  = V_VIS + V_FP + V_SYNC - 1;

  logic [1:0] div;
  logic       tick;
  logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic [9:0] pix_h, pix_v, pix_h_nxt, pix_v_nxt;
  logic       h_wrap, vis;

  always_comb begin
    tick     = (div == 2'(DIV - 1));
    h_wrap   = (hcnt == 10'(H_TOT - 1));
    hcnt_nxt = h_wrap ? 10'd0 : hcnt + 10'd1;
    vcnt_nxt = vcnt;
    if (h_wrap)
      vcnt_nxt = (vcnt == 10'(V_TOT - 1)) ? 10'd0 : vcnt + 10'd1;
    // Pixel whose colour was presented during the elapsed pixel period.
    pix_h_nxt = tick ? hcnt : pix_h;
    pix_v_nxt = tick ? vcnt : pix_v;
    vis       = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div        <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      pix_h      <= '0;
      pix_v      <= '0;
      ADDRH      <= '0;
      ADDRV      <= '0;
      COLOUR_OUT <= '0;
      HS         <= 1'b1;
      VS         <= 1'b1;
      FRAME      <= 1'b0;
    end else begin
      div   <= tick ? 2'd0 : div + 2'd1;
      pix_h <= pix_h_nxt;
      pix_v <= pix_v_nxt;
      // Sync is decoded from the same pixel as COLOUR_OUT, so both land on
      // the same tick edge. Between ticks pix_*_nxt is stable, so HS/VS hold.
      HS <= !((pix_h_nxt >= 10'(HS_FIRST)) && (pix_h_nxt <= 10'(HS_LAST)));
      VS <= !((pix_v_nxt >= 10'(VS_FIRST)) && (pix_v_nxt <= 10'(VS_LAST)));
      if (tick) begin
        hcnt       <= hcnt_nxt;
        vcnt       <= vcnt_nxt;
        // Address runs one pixel ahead of the colour stage.
        ADDRH      <= (hcnt_nxt < 10'(H_VIS)) ? hcnt_nxt : 10'd0;
        ADDRV      <= (vcnt_nxt < 10'(V_VIS)) ? vcnt_nxt[8:0] : 9'd0;
        COLOUR_OUT <= vis ? COLOUR_IN : 12'd0;
        // FRAME is held between ticks, giving a pulse DIV CLKs long.
        FRAME      <= (hcnt_nxt == 10'd0) && (vcnt_nxt == 10'(V_VIS));
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Default-geometry instance: table of hand-computed values at chosen CLK
//   edges across the first two lines, plus an asynchronous reset check.
//   Reduced-geometry instance (15 x 10 raster): every edge over two full frames
//   is checked against a raster model, including a mid-frame reset and restart.
module tb_vga_timing_gen;

  logic        CLK = 1'b0;
  logic        rst_a, rst_s;
  logic [11:0] col_a, col_s;
  logic [9:0]  addrh_a, addrh_s;
  logic [8:0]  addrv_a, addrv_s;
  logic [11:0] cout_a, cout_s;
  logic        hs_a, vs_a, fr_a, hs_s, vs_s, fr_s;

  int n_chk  = 0;
  int n_fail = 0;
  int es;

  always #5 CLK = ~CLK;

  vga_timing_gen u_full (
    .CLK(CLK), .RESETN(rst_a), .COLOUR_IN(col_a),
    .ADDRH(addrh_a), .ADDRV(addrv_a), .COLOUR_OUT(cout_a),
    .HS(hs_a), .VS(vs_a), .FRAME(fr_a)
  );

  // Small raster: line = 8+2+3+2 = 15, frame = 6+1+2+1 = 10 lines.
  vga_timing_gen #(
    .DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .CLK(CLK), .RESETN(rst_s), .COLOUR_IN(col_s),
    .ADDRH(addrh_s), .ADDRV(addrv_s), .COLOUR_OUT(cout_s),
    .HS(hs_s), .VS(vs_s), .FRAME(fr_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int         edge_n;
    logic [9:0] ah;
    logic [8:0] av;
    logic [11:0] col;
    logic       hs, vs, fr;
  } vec_t;

  vec_t tbl[14];

  // Advance the small DUT n edges, checking every output after each edge.
  task automatic run_small(input int n);
    int t, p, q, h, v, hn, vn;
    logic [9:0]  e_ah;
    logic [8:0]  e_av;
    logic [11:0] e_col;
    logic        e_hs, e_vs, e_fr;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      es++;
      #1;
      t = es / 4;
      if (t == 0) begin
        e_ah = 0; e_av = 0; e_col = 0; e_hs = 1; e_vs = 1; e_fr = 0;
      end else begin
        p  = (t - 1) % 150;  h  = p % 15;  v  = p / 15;
        q  = t % 150;        hn = q % 15;  vn = q / 15;
        e_ah  = (hn < 8) ? 10'(hn) : 10'd0;
        e_av  = (vn < 6) ? 9'(vn) : 9'd0;
        e_col = (h < 8 && v < 6) ? {1'b1, 3'(v), 8'(h)} : 12'd0;
        e_hs  = !(h >= 10 && h <= 12);
        e_vs  = !(v >= 7 && v <= 8);
        e_fr  = (hn == 0 && vn == 6);
      end
      chk($sformatf("s_addrh@%0d", es), 32'(addrh_s), 32'(e_ah));
      chk($sformatf("s_addrv@%0d", es), 32'(addrv_s), 32'(e_av));
      chk($sformatf("s_colour@%0d", es), 32'(cout_s), 32'(e_col));
      chk($sformatf("s_hs@%0d", es), 32'(hs_s), 32'(e_hs));
      chk($sformatf("s_vs@%0d", es), 32'(vs_s), 32'(e_vs));
      chk($sformatf("s_frame@%0d", es), 32'(fr_s), 32'(e_fr));
      // The address pattern is only valid in the cycle before a tick; all
      // other cycles carry junk, which must never be sampled. Bit 11 is
      // forced high so pixel (0,0) is distinguishable from blanking.
      if ((es + 1) % 4 == 0) col_s = {1'b1, addrv_s[2:0], addrh_s[7:0]};
      else                   col_s = 12'($urandom);
    end
  endtask

  task automatic chk_reset(input string nm, input logic [9:0] ah, input logic [8:0] av,
                           input logic [11:0] c, input logic h, input logic v, input logic f);
    chk({nm, "_addrh"}, 32'(ah), 32'd0);
    chk({nm, "_addrv"}, 32'(av), 32'd0);
    chk({nm, "_colour"}, 32'(c), 32'd0);
    chk({nm, "_hs"}, 32'(h), 32'd1);
    chk({nm, "_vs"}, 32'(v), 32'd1);
    chk({nm, "_frame"}, 32'(f), 32'd0);
  endtask

  initial begin
    int e;
    rst_a = 1'b0; rst_s = 1'b0;
    col_a = 12'hABC; col_s = 12'h000;

    //        edge   ah   av  col       hs vs fr
    tbl[0]  = '{3,    0,   0, 12'h000,  1, 1, 0};
    tbl[1]  = '{4,    1,   0, 12'hABC,  1, 1, 0};
    tbl[2]  = '{7,    1,   0, 12'hABC,  1, 1, 0};
    tbl[3]  = '{8,    2,   0, 12'hABC,  1, 1, 0};
    tbl[4]  = '{2560, 0,   0, 12'hABC,  1, 1, 0};
    tbl[5]  = '{2564, 0,   0, 12'h000,  1, 1, 0};
    tbl[6]  = '{2624, 0,   0, 12'h000,  1, 1, 0};
    tbl[7]  = '{2628, 0,   0, 12'h000,  0, 1, 0};
    tbl[8]  = '{2631, 0,   0, 12'h000,  0, 1, 0};
    tbl[9]  = '{3008, 0,   0, 12'h000,  0, 1, 0};
    tbl[10] = '{3012, 0,   0, 12'h000,  1, 1, 0};
    tbl[11] = '{3200, 0,   1, 12'h000,  1, 1, 0};
    tbl[12] = '{3204, 1,   1, 12'hABC,  1, 1, 0};
    tbl[13] = '{5828, 0,   1, 12'h000,  0, 1, 0};

    #12;
    chk_reset("rst_full", addrh_a, addrv_a, cout_a, hs_a, vs_a, fr_a);
    chk_reset("rst_small", addrh_s, addrv_s, cout_s, hs_s, vs_s, fr_s);

    // Default geometry, constant colour.
    @(negedge CLK) rst_a = 1'b1;
    e = 0;
    for (int i = 0; i < 14; i++) begin
      while (e < tbl[i].edge_n) begin
        @(posedge CLK);
        e++;
      end
      #1;
      chk($sformatf("f_addrh@%0d", e), 32'(addrh_a), 32'(tbl[i].ah));
      chk($sformatf("f_addrv@%0d", e), 32'(addrv_a), 32'(tbl[i].av));
      chk($sformatf("f_colour@%0d", e), 32'(cout_a), 32'(tbl[i].col));
      chk($sformatf("f_hs@%0d", e), 32'(hs_a), 32'(tbl[i].hs));
      chk($sformatf("f_vs@%0d", e), 32'(vs_a), 32'(tbl[i].vs));
      chk($sformatf("f_frame@%0d", e), 32'(fr_a), 32'(tbl[i].fr));
    end
    // Mid-cycle reset while HS is low and ADDRV is 1: must clear at once.
    #2 rst_a = 1'b0;
    #1 chk_reset("async_full", addrh_a, addrv_a, cout_a, hs_a, vs_a, fr_a);

    // Small geometry: run to tick 71 (hcnt 11, vcnt 4), reset mid-cycle.
    @(negedge CLK) rst_s = 1'b1;
    es = 0;
    run_small(285);
    #2 rst_s = 1'b0;
    #1 chk_reset("async_small", addrh_s, addrv_s, cout_s, hs_s, vs_s, fr_s);
    repeat (3) @(posedge CLK);
    @(negedge CLK) rst_s = 1'b1;
    // Restart from a clean frame: covers first FRAME at edge 360, the
    // 149 -> 0 raster wrap, and a second FRAME 600 CLKs later.
    es = 0;
    run_small(1250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
